// File: rtl/ps2_key_sequencer.sv
// PS/2 keyboard receiver: input sync, 11-bit framing, E0/F0 prefix folding, event FIFO with valid/ready.
// Build option: define PS2_PARITY_CHECK_EN to reject frames failing odd parity.
module ps2_key_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_ext,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  // Two-flop-or-more synchronisers; idle bus level is high
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev;
  logic                   ps2_clk_s, ps2_dat_s, fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DATA};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign ps2_clk_s = clk_sync[SYNC_STAGES-1];
  assign ps2_dat_s = dat_sync[SYNC_STAGES-1];
  assign fall      = clk_prev & ~ps2_clk_s;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_bad, par_bad_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic          byte_done, byte_done_n;
  logic [7:0]    byte_q, byte_n;
  logic          frame_err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bad   <= 1'b0;
      tmo_cnt   <= '0;
      byte_done <= 1'b0;
      byte_q    <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      par_bad   <= par_bad_n;
      tmo_cnt   <= tmo_cnt_n;
      byte_done <= byte_done_n;
      byte_q    <= byte_n;
      frame_err <= frame_err_n;
    end
  end

  // Frame FSM; a PS2_CLK fall takes priority over a same-cycle timeout
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    par_bad_n   = par_bad;
    tmo_cnt_n   = tmo_cnt;
    byte_done_n = 1'b0;
    byte_n      = byte_q;
    frame_err_n = 1'b0;

    if (state == IDLE || fall) begin
      tmo_cnt_n = '0;
    end else if (tmo_cnt != TMO_LAST) begin
      tmo_cnt_n = tmo_cnt + TW'(1);
    end

    if (fall) begin
      case (state)
        IDLE: begin
          if (!ps2_dat_s) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end
        DATA: begin
          shreg_n   = {ps2_dat_s, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_bad_n = ~(^{shreg, ps2_dat_s});
`else
          par_bad_n = 1'b0;
`endif
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (ps2_dat_s && !par_bad) begin
            byte_done_n = 1'b1;
            byte_n      = shreg;
          end else begin
            frame_err_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
      state_n     = IDLE;
      frame_err_n = 1'b1;
    end
  end

  // Prefix flags accumulate until a non-prefix byte consumes them
  logic ext_pend, brk_pend;
  logic is_prefix;

  assign is_prefix = (byte_q == CODE_EXT) || (byte_q == CODE_BRK);

  always_ff @(posedge clk) begin
    if (rst || frame_err) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_done) begin
      if (byte_q == CODE_EXT) begin
        ext_pend <= 1'b1;
      end else if (byte_q == CODE_BRK) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  key_evt_t          mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_n;
  logic              push_req, pop, full, do_push;
  key_evt_t          head;

  assign push_req = byte_done & ~is_prefix;
  assign pop      = key_valid & key_ready;
  assign full     = (count == CW'(FIFO_DEPTH));
  assign do_push  = push_req & (~full | pop);

  always_comb begin
    count_n = count;
    if (do_push && !pop)      count_n = count + CW'(1);
    else if (!do_push && pop) count_n = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count     <= count_n;
      key_valid <= (count_n != '0);
      overflow  <= push_req & full & ~pop;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {ext_pend, brk_pend, byte_q};
  end

  // Show-ahead head, forced to zero while empty
  assign head      = mem[rd_ptr];
  assign key_code  = key_valid ? head.code : 8'h00;
  assign key_break = key_valid & head.brk;
  assign key_ext   = key_valid & head.ext;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Self-checking bench for ps2_key_sequencer: PS/2 frame driver, event monitor and prefix-folding reference model.
module tb_ps2_key_sequencer;

  localparam int SYNC  = 2;
  localparam int TMO   = 300;
  localparam int DEPTH = 4;
  localparam int HALF  = 6;

  logic       clk, rst, PS2_CLK, PS2_DATA, key_ready;
  logic       key_valid, key_break, key_ext, frame_err, overflow;
  logic [7:0] key_code;

  ps2_key_sequencer #(.SYNC_STAGES(SYNC), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_break(key_break), .key_ext(key_ext), .frame_err(frame_err), .overflow(overflow)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ferr_cnt = 0;
  int ovf_cnt  = 0;
  int rise_cyc = -1;
  int stop_cyc = 0;
  bit prev_valid = 1'b0;
  bit m_ext, m_brk;
  bit rand_done;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  event stop_ev;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted event and count error/overflow pulses
  always @(negedge clk) begin
    if (key_valid && key_ready) got_q.push_back({key_ext, key_break, key_code});
    if (frame_err) ferr_cnt++;
    if (overflow) ovf_cnt++;
    if (key_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = key_valid;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input bit b, input bit is_stop);
    PS2_DATA = b;
    wait_clk(HALF);
    PS2_CLK = 1'b0;
    if (is_stop) begin
      stop_cyc = cyc;
      ->stop_ev;
    end
    wait_clk(HALF);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    bit p;
    p = (~^b) ^ bad_par;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit(p, 1'b0);
    ps2_bit(~bad_stop, 1'b1);
    PS2_DATA = 1'b1;
    wait_clk(4);
  endtask

  // Reference: prefixes set flags, any other byte emits {ext,brk,code} and clears them
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      exp_q.push_back({m_ext, m_brk, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_clk(3);
    total++;
    if ({key_valid, key_code, key_break, key_ext, frame_err, overflow} !== 13'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", {key_valid, key_code, key_break, key_ext, frame_err, overflow});
    end
    rst = 1'b0;
    wait_clk(3);
  endtask

  task automatic test_single;
    got_q.delete();
    key_ready = 1'b1;
    rise_cyc = -1;
    send_frame(8'h1C, 1'b0, 1'b0);
    total++;
    if (got_q.size() != 1 || got_q[0] !== 10'h01C) begin
      bad++;
      $display("FAIL single_event got_n=%0d got=%h exp=01c", got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h3FF);
    end
    total++;
    if (rise_cyc - stop_cyc != SYNC + 2) begin
      bad++;
      $display("FAIL single_latency got=%0d exp=%0d", rise_cyc - stop_cyc, SYNC + 2);
    end
    total++;
    if (key_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drained got=%b exp=0", key_valid);
    end
  endtask

  task automatic test_prefix;
    logic [9:0] want [2];
    want[0] = 10'h11C;
    want[1] = 10'h375;
    got_q.delete();
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    total++;
    if (got_q.size() != 2) begin
      bad++;
      $display("FAIL prefix_count got=%0d exp=2", got_q.size());
    end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== want[i]) begin
        bad++;
        $display("FAIL prefix_event%0d got=%h exp=%h", i, got_q[i], want[i]);
      end
    end
  endtask

  task automatic test_parity_stop;
    int e0;
    got_q.delete();
    e0 = ferr_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    total++;
    if (ferr_cnt - e0 != 1 || got_q.size() != 0) begin
      bad++;
      $display("FAIL parity_reject got_err=%0d got_n=%0d exp_err=1 exp_n=0", ferr_cnt - e0, got_q.size());
    end
`else
    total++;
    if (ferr_cnt - e0 != 0 || got_q.size() != 1 || got_q[0] !== 10'h01C) begin
      bad++;
      $display("FAIL parity_ignored got_err=%0d got_n=%0d exp_err=0 exp_n=1", ferr_cnt - e0, got_q.size());
    end
`endif
    got_q.delete();
    e0 = ferr_cnt;
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    total++;
    if (ferr_cnt - e0 != 1 || got_q.size() != 0) begin
      bad++;
      $display("FAIL bad_stop got_err=%0d got_n=%0d exp_err=1 exp_n=0", ferr_cnt - e0, got_q.size());
    end
    send_frame(8'h1C, 1'b0, 1'b0);
    total++;
    if (got_q.size() != 1 || got_q[0] !== 10'h01C) begin
      bad++;
      $display("FAIL err_clears_brk got_n=%0d got=%h exp=01c", got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h3FF);
    end
  endtask

  task automatic test_timeout;
    int e0;
    got_q.delete();
    send_frame(8'hE0, 1'b0, 1'b0);
    e0 = ferr_cnt;
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    wait_clk(TMO - 40);
    total++;
    if (ferr_cnt - e0 != 0) begin
      bad++;
      $display("FAIL timeout_early got=%0d exp=0", ferr_cnt - e0);
    end
    wait_clk(60);
    total++;
    if (ferr_cnt - e0 != 1) begin
      bad++;
      $display("FAIL timeout_err got=%0d exp=1", ferr_cnt - e0);
    end
    send_frame(8'h1C, 1'b0, 1'b0);
    total++;
    if (got_q.size() != 1 || got_q[0] !== 10'h01C || ferr_cnt - e0 != 1) begin
      bad++;
      $display("FAIL timeout_recover got_n=%0d got=%h err=%0d exp=01c err=1", got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h3FF, ferr_cnt - e0);
    end
  endtask

  task automatic test_overflow;
    int o0;
    got_q.delete();
    key_ready = 1'b0;
    o0 = ovf_cnt;
    for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 1'b0, 1'b0);
    total++;
    if (ovf_cnt - o0 != 1) begin
      bad++;
      $display("FAIL overflow_pulse got=%0d exp=1", ovf_cnt - o0);
    end
    total++;
    if (key_valid !== 1'b1 || {key_ext, key_break, key_code} !== 10'h001) begin
      bad++;
      $display("FAIL overflow_head got=%b/%h exp=1/001", key_valid, {key_ext, key_break, key_code});
    end
    key_ready = 1'b1;
    wait_clk(10);
    total++;
    if (got_q.size() != DEPTH) begin
      bad++;
      $display("FAIL overflow_drain_n got=%0d exp=%0d", got_q.size(), DEPTH);
    end
    for (int i = 0; i < DEPTH && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== 10'(i + 1)) begin
        bad++;
        $display("FAIL overflow_order%0d got=%h exp=%h", i, got_q[i], 10'(i + 1));
      end
    end
    total++;
    if ({key_valid, key_ext, key_break, key_code} !== 11'h0) begin
      bad++;
      $display("FAIL empty_outputs got=%h exp=0", {key_valid, key_ext, key_break, key_code});
    end
  endtask

  task automatic test_full_push_pop;
    int o0;
    got_q.delete();
    key_ready = 1'b0;
    o0 = ovf_cnt;
    for (int i = 1; i <= DEPTH; i++) send_frame(8'(8'h20 + i), 1'b0, 1'b0);
    fork
      send_frame(8'h2F, 1'b0, 1'b0);
      begin
        @(stop_ev);
        wait_clk(SYNC + 1);
        key_ready = 1'b1;
        wait_clk(1);
        key_ready = 1'b0;
      end
    join
    total++;
    if (ovf_cnt - o0 != 0 || got_q.size() != 1) begin
      bad++;
      $display("FAIL full_pushpop got_ovf=%0d got_n=%0d exp_ovf=0 exp_n=1", ovf_cnt - o0, got_q.size());
    end
    key_ready = 1'b1;
    wait_clk(10);
    total++;
    if (got_q.size() != DEPTH + 1) begin
      bad++;
      $display("FAIL full_pushpop_n got=%0d exp=%0d", got_q.size(), DEPTH + 1);
    end
    for (int i = 0; i < DEPTH + 1 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== ((i == DEPTH) ? 10'h02F : 10'(8'h21 + i))) begin
        bad++;
        $display("FAIL full_pushpop_order%0d got=%h exp=%h", i, got_q[i], (i == DEPTH) ? 10'h02F : 10'(8'h21 + i));
      end
    end
  endtask

  task automatic test_reset_mid;
    got_q.delete();
    key_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    rst = 1'b1;
    wait_clk(2);
    total++;
    if ({key_valid, key_code, key_break, key_ext, frame_err, overflow} !== 13'h0) begin
      bad++;
      $display("FAIL midreset_outputs got=%h exp=0", {key_valid, key_code, key_break, key_ext, frame_err, overflow});
    end
    rst = 1'b0;
    wait_clk(2);
    key_ready = 1'b1;
    send_frame(8'h75, 1'b0, 1'b0);
    total++;
    if (got_q.size() != 1 || got_q[0] !== 10'h075) begin
      bad++;
      $display("FAIL midreset_ext got_n=%0d got=%h exp=075", got_q.size(), (got_q.size() > 0) ? got_q[0] : 10'h3FF);
    end
  endtask

  task automatic test_random;
    int e0, o0;
    logic [7:0] b;
    got_q.delete();
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    e0 = ferr_cnt;
    o0 = ovf_cnt;
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          case ($urandom_range(0, 3))
            0: b = 8'hE0;
            1: b = 8'hF0;
            default: b = 8'($urandom_range(0, 255));
          endcase
          send_frame(b, 1'b0, 1'b0);
          model_byte(b);
        end
        send_frame(8'h5A, 1'b0, 1'b0);
        model_byte(8'h5A);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          wait_clk(1);
          key_ready = 1'($urandom_range(0, 1));
        end
        key_ready = 1'b1;
      end
    join
    wait_clk(10);
    total++;
    if (got_q.size() != exp_q.size() || ferr_cnt != e0 || ovf_cnt != o0) begin
      bad++;
      $display("FAIL random_count got_n=%0d exp_n=%0d err=%0d ovf=%0d", got_q.size(), exp_q.size(), ferr_cnt - e0, ovf_cnt - o0);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL random_event%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    PS2_CLK   = 1'b1;
    PS2_DATA  = 1'b1;
    key_ready = 1'b0;
    test_reset();
    test_single();
    test_prefix();
    test_parity_stop();
    test_timeout();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
